// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI button front end: status byte ranges,
// the data-byte count helper and the state encodings.
package midi_pkg;

  // Channel voice status bytes that open a message
  localparam logic [7:0] STATUS_MIN   = 8'h80;
  localparam logic [7:0] STATUS_MAX   = 8'hEF;
  // Program change / channel pressure carry a single data byte
  localparam logic [7:0] ONE_DATA_MIN = 8'hC0;
  localparam logic [7:0] ONE_DATA_MAX = 8'hDF;

  // What the front end currently holds from the MIDI input
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    READY    = 2'd1,
    ASSIGNED = 2'd2
  } midi_in_state_e;

  // Serial receiver phases
  typedef enum logic [2:0] {
    UART_IDLE      = 3'd0,
    UART_START     = 3'd1,
    UART_DATA      = 3'd2,
    UART_STOP      = 3'd3,
    UART_WAIT_HIGH = 3'd4
  } uart_state_e;

  // Number of data bytes that follow a channel status byte
  function automatic logic [1:0] data_byte_count(input logic [7:0] status_byte);
    if (status_byte >= ONE_DATA_MIN && status_byte <= ONE_DATA_MAX) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

  // True for bytes that start a new channel message
  function automatic logic is_channel_status(input logic [7:0] b);
    return (b >= STATUS_MIN) && (b <= STATUS_MAX);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stability counter. The output only
// follows the input after 2^DEBOUNCE_CNT consecutive samples that differ
// from the current output; any sample equal to the output restarts the count.
module debounce_filter
  import midi_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic                    sync1_q, sync1_d;
  logic                    sync2_q, sync2_d;
  logic                    dout_q, dout_d;
  logic [DEBOUNCE_CNT-1:0] cnt_q, cnt_d;

  // Next-state: shift the synchronizer, count differing samples, flip output when full
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    dout_d  = dout_q;
    cnt_d   = '0;
    if (sync2_q != dout_q) begin
      if (&cnt_q) begin
        dout_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers; inputs are active-low so everything idles high
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dout_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/midi_button_frontend.sv
// MIDI footswitch front end: debounces the board button and four dual-contact
// footswitches, receives MIDI serial bytes, parses channel messages with
// running status, and lets a footswitch claim the held message in save mode.
module midi_button_frontend
  import midi_pkg::*;
#(
  parameter int CLK_PER_BIT  = 3200,
  parameter int DEBOUNCE_CNT = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       midi_rx,
  input  logic       board_btn,
  input  logic       btn2_pin_1,
  input  logic       btn2_pin_2,
  input  logic       btn3_pin_1,
  input  logic       btn3_pin_2,
  input  logic       btn4_pin_1,
  input  logic       btn4_pin_2,
  input  logic       btn5_pin_1,
  input  logic       btn5_pin_2,
  output logic       save_mode,
  output logic [2:0] btn_index,
  output logic [7:0] status,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [1:0] bytes_cnt,
  output logic       msg_valid,
  output logic [1:0] midi_in_state
);

  localparam int CNT_W = (CLK_PER_BIT > 2) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- buttons
  // Index 0 is the board button, then pin_1/pin_2 pairs of btn2..btn5
  logic [8:0] raw_n;
  logic [8:0] db_n;
  logic [3:0] btn_pressed;

  assign raw_n = {btn5_pin_2, btn5_pin_1, btn4_pin_2, btn4_pin_1,
                  btn3_pin_2, btn3_pin_1, btn2_pin_2, btn2_pin_1, board_btn};

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_db
      debounce_filter #(
        .DEBOUNCE_CNT(DEBOUNCE_CNT)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .din  (raw_n[gi]),
        .dout (db_n[gi])
      );
    end
    for (gi = 0; gi < 4; gi++) begin : g_pressed
      // Either contact closing counts as the switch being pressed
      assign btn_pressed[gi] = ~db_n[2*gi+1] | ~db_n[2*gi+2];
    end
  endgenerate

  logic           board_prev_q, board_prev_d;
  logic [3:0]     btn_prev_q, btn_prev_d;
  logic           save_mode_q, save_mode_d;
  logic [2:0]     btn_index_q, btn_index_d;
  logic           assigned_q, assigned_d;
  logic           msg_valid_q;
  midi_in_state_e mis;
  logic [3:0]     press_evt;
  logic [2:0]     press_idx;

  // Held-message state derived from the registered valid/assigned flags
  always_comb begin
    mis = NONE;
    if (msg_valid_q) begin
      mis = assigned_q ? ASSIGNED : READY;
    end
  end

  // Press edge detection, priority pick, save-mode gating and assignment flag
  always_comb begin
    board_prev_d = db_n[0];
    save_mode_d  = save_mode_q ^ (board_prev_q & ~db_n[0]);
    btn_prev_d   = btn_pressed;
    press_evt    = btn_pressed & ~btn_prev_q;
    press_idx    = 3'd0;
    // Walk downwards so the lowest simultaneous index is the one kept
    for (int i = 3; i >= 0; i--) begin
      if (press_evt[i]) begin
        press_idx = 3'(i + 1);
      end
    end
    btn_index_d = 3'd0;
    if (press_idx != 3'd0 && (!save_mode_q || mis == READY)) begin
      btn_index_d = press_idx;
    end
    assigned_d = assigned_q;
    if (!msg_valid_q) begin
      assigned_d = 1'b0;
    end else if (mis == READY && btn_index_q != 3'd0) begin
      assigned_d = 1'b1;
    end
  end

  // Button-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      board_prev_q <= 1'b1;
      btn_prev_q   <= 4'd0;
      save_mode_q  <= 1'b0;
      btn_index_q  <= 3'd0;
      assigned_q   <= 1'b0;
    end else begin
      board_prev_q <= board_prev_d;
      btn_prev_q   <= btn_prev_d;
      save_mode_q  <= save_mode_d;
      btn_index_q  <= btn_index_d;
      assigned_q   <= assigned_d;
    end
  end

  // ---------------------------------------------------------------- UART rx
  logic              rx_sync1_q, rx_sync1_d;
  logic              rx_sync2_q, rx_sync2_d;
  logic              rx_prev_q, rx_prev_d;
  uart_state_e       uart_state_q, uart_state_d;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              rx_byte_valid_q, rx_byte_valid_d;
  logic [7:0]        rx_byte_q, rx_byte_d;

  // Receiver FSM: mid-start glitch check, 8 data bits LSB first, stop check
  always_comb begin
    rx_sync1_d      = midi_rx;
    rx_sync2_d      = rx_sync1_q;
    rx_prev_d       = rx_sync2_q;
    uart_state_d    = uart_state_q;
    clk_cnt_d       = clk_cnt_q + 1'b1;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    rx_byte_valid_d = 1'b0;
    rx_byte_d       = rx_byte_q;
    case (uart_state_q)
      UART_IDLE: begin
        clk_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) begin
          uart_state_d = UART_START;
        end
      end
      UART_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d    = '0;
          bit_cnt_d    = 3'd0;
          uart_state_d = rx_sync2_q ? UART_IDLE : UART_DATA;
        end
      end
      UART_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            uart_state_d = UART_STOP;
          end
        end
      end
      UART_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (rx_sync2_q) begin
            rx_byte_valid_d = 1'b1;
            rx_byte_d       = shift_q;
            uart_state_d    = UART_IDLE;
          end else begin
            // Framing error: drop the byte and wait for the line to recover
            uart_state_d = UART_WAIT_HIGH;
          end
        end
      end
      UART_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rx_sync2_q) begin
          uart_state_d = UART_IDLE;
        end
      end
      default: begin
        clk_cnt_d    = '0;
        uart_state_d = UART_IDLE;
      end
    endcase
  end

  // Receiver registers; reset drops any partially received byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_sync1_q      <= 1'b1;
      rx_sync2_q      <= 1'b1;
      rx_prev_q       <= 1'b1;
      uart_state_q    <= UART_IDLE;
      clk_cnt_q       <= '0;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 8'd0;
      rx_byte_valid_q <= 1'b0;
      rx_byte_q       <= 8'd0;
    end else begin
      rx_sync1_q      <= rx_sync1_d;
      rx_sync2_q      <= rx_sync2_d;
      rx_prev_q       <= rx_prev_d;
      uart_state_q    <= uart_state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      rx_byte_q       <= rx_byte_d;
    end
  end

  // ---------------------------------------------------------------- parser
  logic [7:0] run_status_q, run_status_d;
  logic       run_valid_q, run_valid_d;
  logic       in_msg_q, in_msg_d;
  logic       second_q, second_d;
  logic [7:0] data1_tmp_q, data1_tmp_d;
  logic [7:0] status_q, status_d;
  logic [7:0] data1_q, data1_d;
  logic [7:0] data2_q, data2_d;
  logic [1:0] bytes_cnt_q, bytes_cnt_d;
  logic       done_q, done_d;
  logic       msg_valid_d;
  logic       take_data;

  // Message assembly; msg_valid rises the cycle after the final data byte
  always_comb begin
    run_status_d = run_status_q;
    run_valid_d  = run_valid_q;
    in_msg_d     = in_msg_q;
    second_d     = second_q;
    data1_tmp_d  = data1_tmp_q;
    status_d     = status_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    bytes_cnt_d  = bytes_cnt_q;
    done_d       = 1'b0;
    msg_valid_d  = msg_valid_q | done_q;
    take_data    = 1'b0;
    if (rx_byte_valid_q) begin
      if (rx_byte_q[7]) begin
        // System bytes (0xF0..0xFF) fall through untouched
        if (is_channel_status(rx_byte_q)) begin
          run_status_d = rx_byte_q;
          run_valid_d  = 1'b1;
          in_msg_d     = 1'b1;
          second_d     = 1'b0;
          msg_valid_d  = 1'b0;
        end
      end else if (in_msg_q) begin
        take_data = 1'b1;
      end else if (run_valid_q) begin
        // Running status: this data byte opens a fresh message
        take_data   = 1'b1;
        msg_valid_d = 1'b0;
      end
    end
    if (take_data) begin
      if (second_q) begin
        status_d    = run_status_q;
        data1_d     = data1_tmp_q;
        data2_d     = rx_byte_q;
        bytes_cnt_d = 2'd3;
        done_d      = 1'b1;
        in_msg_d    = 1'b0;
        second_d    = 1'b0;
      end else if (data_byte_count(run_status_q) == 2'd1) begin
        status_d    = run_status_q;
        data1_d     = rx_byte_q;
        data2_d     = 8'd0;
        bytes_cnt_d = 2'd2;
        done_d      = 1'b1;
        in_msg_d    = 1'b0;
      end else begin
        data1_tmp_d = rx_byte_q;
        second_d    = 1'b1;
        in_msg_d    = 1'b1;
      end
    end
  end

  // Parser registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_status_q <= 8'd0;
      run_valid_q  <= 1'b0;
      in_msg_q     <= 1'b0;
      second_q     <= 1'b0;
      data1_tmp_q  <= 8'd0;
      status_q     <= 8'd0;
      data1_q      <= 8'd0;
      data2_q      <= 8'd0;
      bytes_cnt_q  <= 2'd0;
      done_q       <= 1'b0;
      msg_valid_q  <= 1'b0;
    end else begin
      run_status_q <= run_status_d;
      run_valid_q  <= run_valid_d;
      in_msg_q     <= in_msg_d;
      second_q     <= second_d;
      data1_tmp_q  <= data1_tmp_d;
      status_q     <= status_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      bytes_cnt_q  <= bytes_cnt_d;
      done_q       <= done_d;
      msg_valid_q  <= msg_valid_d;
    end
  end

  assign save_mode     = save_mode_q;
  assign btn_index     = btn_index_q;
  assign status        = status_q;
  assign data1         = data1_q;
  assign data2         = data2_q;
  assign bytes_cnt     = bytes_cnt_q;
  assign msg_valid     = msg_valid_q;
  assign midi_in_state = mis;

endmodule

// File: tb/tb_midi_button_frontend.sv
// Directed bench for midi_button_frontend with CLK_PER_BIT=16, DEBOUNCE_CNT=4.
module tb_midi_button_frontend;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       midi_rx = 1'b1;
  logic       board_btn = 1'b1;
  logic [7:0] pin_n = 8'hFF;  // {b5p2,b5p1,b4p2,b4p1,b3p2,b3p1,b2p2,b2p1}
  logic       save_mode;
  logic [2:0] btn_index;
  logic [7:0] status, data1, data2;
  logic [1:0] bytes_cnt;
  logic       msg_valid;
  logic [1:0] midi_in_state;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  midi_button_frontend #(
    .CLK_PER_BIT (16),
    .DEBOUNCE_CNT(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .midi_rx      (midi_rx),
    .board_btn    (board_btn),
    .btn2_pin_1   (pin_n[0]),
    .btn2_pin_2   (pin_n[1]),
    .btn3_pin_1   (pin_n[2]),
    .btn3_pin_2   (pin_n[3]),
    .btn4_pin_1   (pin_n[4]),
    .btn4_pin_2   (pin_n[5]),
    .btn5_pin_1   (pin_n[6]),
    .btn5_pin_2   (pin_n[7]),
    .save_mode    (save_mode),
    .btn_index    (btn_index),
    .status       (status),
    .data1        (data1),
    .data2        (data2),
    .bytes_cnt    (bytes_cnt),
    .msg_valid    (msg_valid),
    .midi_in_state(midi_in_state)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Serial frame: start, 8 data bits LSB first, chosen stop level, 4 idle bits
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    midi_rx = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      midi_rx = b[i];
      tick(16);
    end
    midi_rx = stop_bit;
    tick(16);
    midi_rx = 1'b1;
    tick(4);
    $display("tx byte %02h stop=%0b -> status=%02h d1=%02h d2=%02h cnt=%0d valid=%0b state=%0d",
             b, stop_bit, status, data1, data2, bytes_cnt, msg_valid, midi_in_state);
  endtask

  // Drive the pins (low where mask is set) and observe btn_index for n cycles
  task automatic press_watch(input logic [7:0] low_mask, input int n,
                             output int pulses, output logic [2:0] idx,
                             output int first_at, output int max_w);
    int w;
    pin_n = ~low_mask;
    pulses = 0; idx = 3'd0; first_at = -1; max_w = 0; w = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (btn_index != 3'd0) begin
        if (w == 0) begin
          pulses++;
          if (first_at < 0) begin
            first_at = k;
            idx = btn_index;
          end
        end
        w++;
        if (w > max_w) max_w = w;
      end else begin
        w = 0;
      end
    end
    $display("pins=%02h pulses=%0d idx=%0d first=%0d width=%0d save=%0b state=%0d",
             pin_n, pulses, idx, first_at, max_w, save_mode, midi_in_state);
    @(negedge clk);
  endtask

  task automatic test_reset;
    int nz;
    tick(3);
    total++;
    if ({save_mode, btn_index, status, data1, data2, bytes_cnt, msg_valid, midi_in_state} !== 33'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {save_mode, btn_index, status, data1, data2, bytes_cnt, msg_valid, midi_in_state});
    end
    rst = 1'b1;
    nz = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (btn_index != 3'd0 || save_mode != 1'b0) nz++;
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL reset_release_quiet: got %0d active cycles required 0", nz);
    end
    @(negedge clk);
  endtask

  task automatic test_three_byte;
    send_byte(8'hB0, 1'b1);
    send_byte(8'h2E, 1'b1);
    send_byte(8'h7F, 1'b1);
    total++; if (status !== 8'hB0) begin bad++; $display("FAIL cc_status: got %h required b0", status); end
    total++; if (data1 !== 8'h2E) begin bad++; $display("FAIL cc_data1: got %h required 2e", data1); end
    total++; if (data2 !== 8'h7F) begin bad++; $display("FAIL cc_data2: got %h required 7f", data2); end
    total++; if (bytes_cnt !== 2'd3) begin bad++; $display("FAIL cc_bytes: got %0d required 3", bytes_cnt); end
    total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL cc_valid: got %0b required 1", msg_valid); end
    total++; if (midi_in_state !== 2'd1) begin bad++; $display("FAIL cc_state: got %0d required 1", midi_in_state); end
  endtask

  task automatic test_running_status;
    send_byte(8'hC0, 1'b1);
    total++;
    if (msg_valid !== 1'b0) begin bad++; $display("FAIL pc_status_clears_valid: got %0b required 0", msg_valid); end
    send_byte(8'h42, 1'b1);
    total++;
    if ({status, data1, data2, bytes_cnt, msg_valid} !== {8'hC0, 8'h42, 8'h00, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL pc_first: got %h required %h", {status, data1, data2, bytes_cnt, msg_valid},
               {8'hC0, 8'h42, 8'h00, 2'd2, 1'b1});
    end
    send_byte(8'h43, 1'b1);
    total++;
    if ({status, data1, data2, bytes_cnt, msg_valid} !== {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL pc_running: got %h required %h", {status, data1, data2, bytes_cnt, msg_valid},
               {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1});
    end
  endtask

  task automatic test_bad_bytes;
    // 0x55 would be taken by running status if the framing error were ignored
    send_byte(8'h55, 1'b0);
    total++;
    if ({status, data1, data2, bytes_cnt, msg_valid} !== {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL bad_stop: got %h required %h", {status, data1, data2, bytes_cnt, msg_valid},
               {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1});
    end
    send_byte(8'hF8, 1'b1);
    total++;
    if ({status, data1, data2, bytes_cnt, msg_valid} !== {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1}) begin
      bad++;
      $display("FAIL realtime_ignored: got %h required %h", {status, data1, data2, bytes_cnt, msg_valid},
               {8'hC0, 8'h43, 8'h00, 2'd2, 1'b1});
    end
    send_byte(8'h44, 1'b1);
    total++;
    if ({data1, msg_valid, midi_in_state} !== {8'h44, 1'b1, 2'd1}) begin
      bad++;
      $display("FAIL recover_after_errors: got %h required %h", {data1, msg_valid, midi_in_state},
               {8'h44, 1'b1, 2'd1});
    end
  endtask

  task automatic test_debounce;
    int p, f, w;
    logic [2:0] idx;
    // Three-cycle bounce on btn3_pin_2, then held low
    pin_n[3] = 1'b0; tick(1);
    pin_n[3] = 1'b1; tick(1);
    pin_n[3] = 1'b0; tick(1);
    pin_n[3] = 1'b1; tick(1);
    press_watch(8'h08, 40, p, idx, f, w);
    total++; if (p != 1) begin bad++; $display("FAIL deb_pulses: got %0d required 1", p); end
    total++; if (idx !== 3'd2) begin bad++; $display("FAIL deb_index: got %0d required 2", idx); end
    // 2 sync stages + 16 stable samples (first counted 2 edges in) + registered output
    total++; if (f != 19) begin bad++; $display("FAIL deb_latency: got %0d required 19", f); end
    total++; if (w != 1) begin bad++; $display("FAIL deb_width: got %0d required 1", w); end
    total++;
    if (midi_in_state !== 2'd2) begin bad++; $display("FAIL deb_assigns: got %0d required 2", midi_in_state); end
    press_watch(8'h00, 40, p, idx, f, w);
    total++; if (p != 0) begin bad++; $display("FAIL deb_release: got %0d pulses required 0", p); end
  endtask

  task automatic test_save_mode;
    int p, f, w;
    logic [2:0] idx;
    board_btn = 1'b0; tick(30);
    total++; if (save_mode !== 1'b1) begin bad++; $display("FAIL save_toggle_on: got %0b required 1", save_mode); end
    board_btn = 1'b1; tick(30);
    total++; if (save_mode !== 1'b1) begin bad++; $display("FAIL save_release_hold: got %0b required 1", save_mode); end
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h64, 1'b1);
    total++;
    if ({status, data1, data2, bytes_cnt, midi_in_state} !== {8'h90, 8'h3C, 8'h64, 2'd3, 2'd1}) begin
      bad++;
      $display("FAIL note_ready: got %h required %h", {status, data1, data2, bytes_cnt, midi_in_state},
               {8'h90, 8'h3C, 8'h64, 2'd3, 2'd1});
    end
    press_watch(8'h10, 40, p, idx, f, w);
    total++;
    if (p != 1 || idx !== 3'd3 || w != 1) begin
      bad++;
      $display("FAIL save_btn4: got pulses=%0d idx=%0d width=%0d required 1/3/1", p, idx, w);
    end
    total++;
    if (midi_in_state !== 2'd2) begin bad++; $display("FAIL save_assigned: got %0d required 2", midi_in_state); end
    press_watch(8'h00, 40, p, idx, f, w);
    send_byte(8'h90, 1'b1);
    total++;
    if ({msg_valid, midi_in_state} !== {1'b0, 2'd0}) begin
      bad++;
      $display("FAIL new_status_state: got %h required 0", {msg_valid, midi_in_state});
    end
    // No message held: press in save mode must be dropped
    press_watch(8'h01, 40, p, idx, f, w);
    total++; if (p != 0) begin bad++; $display("FAIL save_drop: got %0d pulses required 0", p); end
    press_watch(8'h00, 40, p, idx, f, w);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h00, 1'b1);
    total++;
    if ({data1, data2, bytes_cnt, midi_in_state} !== {8'h3C, 8'h00, 2'd3, 2'd1}) begin
      bad++;
      $display("FAIL note_off_ready: got %h required %h", {data1, data2, bytes_cnt, midi_in_state},
               {8'h3C, 8'h00, 2'd3, 2'd1});
    end
    // btn2 and btn5 together: lowest index wins
    press_watch(8'h42, 40, p, idx, f, w);
    total++;
    if (p != 1 || idx !== 3'd1) begin
      bad++;
      $display("FAIL priority: got pulses=%0d idx=%0d required 1/1", p, idx);
    end
    press_watch(8'h00, 40, p, idx, f, w);
  endtask

  task automatic test_reset_mid_byte;
    @(negedge clk);
    midi_rx = 1'b0;
    tick(16);
    midi_rx = 1'b1;
    tick(30);
    #2 rst = 1'b0;
    #1;
    total++;
    if ({save_mode, btn_index, status, data1, data2, bytes_cnt, msg_valid, midi_in_state} !== 33'd0) begin
      bad++;
      $display("FAIL async_reset: got %h required 0",
               {save_mode, btn_index, status, data1, data2, bytes_cnt, msg_valid, midi_in_state});
    end
    midi_rx = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(5);
    send_byte(8'hB0, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    total++;
    if ({save_mode, status, data1, data2, bytes_cnt, midi_in_state} !== {1'b0, 8'hB0, 8'h01, 8'h02, 2'd3, 2'd1}) begin
      bad++;
      $display("FAIL after_reset_msg: got %h required %h",
               {save_mode, status, data1, data2, bytes_cnt, midi_in_state},
               {1'b0, 8'hB0, 8'h01, 8'h02, 2'd3, 2'd1});
    end
  endtask

  initial begin
    test_reset();
    test_three_byte();
    test_running_status();
    test_bad_bytes();
    test_debounce();
    test_save_mode();
    test_reset_mid_byte();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
